// File: rtl/sched_pkg.sv
// sched_pkg: shared types, defaults and helpers for the inertial event scheduler
package sched_pkg;
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_e;
  localparam int DW_DEF = 8;
  localparam int VCW_DEF = 16;
  // Saturating increment of the low w bits of v
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] m;
    m = ~(32'hFFFF_FFFF << w);
    return ((v & m) == m) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/inertial_event_sched_if.sv
// inertial_event_sched_if: stimulus/response bundle between drivers and the scheduler
interface inertial_event_sched_if #(
  parameter int NCH = 4,
  parameter int DW = 8,
  parameter int VCW = 16
);
  logic tick_i;
  logic [NCH-1:0] in_i;
  logic [NCH*DW-1:0] rise_dly_i;
  logic [NCH*DW-1:0] fall_dly_i;
  logic [NCH-1:0] out_o;
  logic [NCH-1:0] pending_o;
  logic [NCH-1:0] unstable_o;
  logic next_valid_o;
  logic [DW-1:0] next_dly_o;
  logic [VCW-1:0] vac_cnt_o;
  modport master (
    output tick_i, in_i, rise_dly_i, fall_dly_i,
    input out_o, pending_o, unstable_o, next_valid_o, next_dly_o, vac_cnt_o
  );
  modport slave (
    input tick_i, in_i, rise_dly_i, fall_dly_i,
    output out_o, pending_o, unstable_o, next_valid_o, next_dly_o, vac_cnt_o
  );
endinterface

// File: rtl/min_tree.sv
// min_tree: combinational masked-minimum reduction, recursive halving for log2 depth
module min_tree #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic [N-1:0]   vld_i,
  input  logic [N*W-1:0] val_i,
  output logic           vld_o,
  output logic [W-1:0]   val_o
);
  if (N == 1) begin : g_leaf
    assign vld_o = vld_i[0];
    assign val_o = vld_i[0] ? val_i : '0;
  end else begin : g_node
    localparam int L = N / 2;
    logic lv, hv;
    logic [W-1:0] lval, hval;
    min_tree #(.N(L), .W(W)) u_lo (
      .vld_i(vld_i[L-1:0]), .val_i(val_i[L*W-1:0]), .vld_o(lv), .val_o(lval)
    );
    min_tree #(.N(N-L), .W(W)) u_hi (
      .vld_i(vld_i[N-1:L]), .val_i(val_i[N*W-1:L*W]), .vld_o(hv), .val_o(hval)
    );
    // Invalid halves present zero, so an all-idle subtree reduces to 0
    assign vld_o = lv | hv;
    assign val_o = !hv ? lval : !lv ? hval : (lval <= hval) ? lval : hval;
  end
endmodule

// File: rtl/inertial_event_sched.sv
// inertial_event_sched: per-channel rise/fall delayed-event scheduler with next-event query
module inertial_event_sched
  import sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW = DW_DEF,
  parameter bit CANCEL = 1'b1,
  parameter bit RESET_VAL = 1'b0,
  parameter int VCW = VCW_DEF
) (
  input logic clk,
  input logic rst,
  inertial_event_sched_if.slave bus
);
  logic [NCH-1:0] pend_v, cancel_v;
  logic [NCH*DW-1:0] cnt_v;
  logic [VCW-1:0] vac_q, vac_d;
  logic tree_vld, nv_q;
  logic [DW-1:0] tree_val, nd_q;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_e state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d, dly;
    logic tgt_q, tgt_d, out_q, out_d, rev_q, unst_q, fire, rev, cancel;
    assign dly = bus.in_i[c] ? bus.rise_dly_i[c*DW +: DW] : bus.fall_dly_i[c*DW +: DW];
    assign fire = (state_q == PEND) && bus.tick_i && (cnt_q == DW'(1));
    assign rev = (state_q == PEND) && (bus.in_i[c] != tgt_q);
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q <= '0;
        tgt_q <= RESET_VAL;
        out_q <= RESET_VAL;
        rev_q <= 1'b0;
        unst_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q <= cnt_d;
        tgt_q <= tgt_d;
        out_q <= out_d;
        rev_q <= rev;
        unst_q <= rev & ~rev_q & ~fire;
      end
    end
    // Fire beats a same-cycle reversal; a zero delay still waits one tick
    always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      tgt_d = tgt_q;
      out_d = out_q;
      cancel = 1'b0;
      if (state_q == IDLE) begin
        if (bus.in_i[c] != out_q) begin
          state_d = PEND;
          tgt_d = bus.in_i[c];
          cnt_d = (dly == '0) ? DW'(1) : dly;
        end
      end else if (fire) begin
        state_d = IDLE;
        out_d = tgt_q;
        cnt_d = '0;
      end else if (rev && CANCEL) begin
        state_d = IDLE;
        cnt_d = '0;
        cancel = 1'b1;
      end else if (bus.tick_i) begin
        cnt_d = cnt_q - DW'(1);
      end
    end
    assign pend_v[c] = (state_q == PEND);
    assign cancel_v[c] = cancel;
    assign cnt_v[c*DW +: DW] = cnt_q;
    assign bus.out_o[c] = out_q;
    assign bus.pending_o[c] = pend_v[c];
    assign bus.unstable_o[c] = unst_q;
  end
  always_comb begin
    vac_d = vac_q;
    for (int c = 0; c < NCH; c++)
      if (cancel_v[c]) vac_d = VCW'(sat_inc(32'(vac_d), VCW));
  end
  min_tree #(.N(NCH), .W(DW)) u_min (
    .vld_i(pend_v), .val_i(cnt_v), .vld_o(tree_vld), .val_o(tree_val)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vac_q <= '0;
      nv_q <= 1'b0;
      nd_q <= '0;
    end else begin
      vac_q <= vac_d;
      nv_q <= tree_vld;
      nd_q <= tree_val;
    end
  end
  assign bus.vac_cnt_o = vac_q;
  assign bus.next_valid_o = nv_q;
  assign bus.next_dly_o = nd_q;
endmodule

// File: tb/tb_inertial_event_sched.sv
// tb_inertial_event_sched: directed self-checking bench, CANCEL=1 (a) and CANCEL=0 (b) instances
module tb_inertial_event_sched;
  typedef struct {
    logic [3:0]  in;
    logic        tick;
    logic [3:0]  out;
    logic [3:0]  pend;
    logic [3:0]  unst;
    logic [15:0] vac;
    logic        nv;
    logic [7:0]  nd;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  vec_t tbl[21];
  always #5 clk = ~clk;
  inertial_event_sched_if #(.NCH(4), .DW(8), .VCW(16)) a_if ();
  inertial_event_sched_if #(.NCH(4), .DW(8), .VCW(16)) b_if ();
  inertial_event_sched #(.NCH(4), .DW(8), .CANCEL(1'b1), .RESET_VAL(1'b0), .VCW(16)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave)
  );
  inertial_event_sched #(.NCH(4), .DW(8), .CANCEL(1'b0), .RESET_VAL(1'b0), .VCW(16)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d @%0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_dly(input bit b, input int c, input logic [7:0] r, input logic [7:0] f);
    if (b) begin
      b_if.rise_dly_i[c*8 +: 8] = r;
      b_if.fall_dly_i[c*8 +: 8] = f;
    end else begin
      a_if.rise_dly_i[c*8 +: 8] = r;
      a_if.fall_dly_i[c*8 +: 8] = f;
    end
  endtask
  initial begin
    int rise_at, bad, a_u, b_u, a_hi, b_rise, b_fall;
    //            in       tick  out      pend     unst     vac     nv    nd
    tbl[0]  = '{4'b0001, 1'b1, 4'b0000, 4'b0001, 4'b0000, 16'd0, 1'b0, 8'd0};
    tbl[1]  = '{4'b0001, 1'b1, 4'b0000, 4'b0001, 4'b0000, 16'd0, 1'b1, 8'd2};
    tbl[2]  = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000, 16'd0, 1'b1, 8'd1};
    tbl[3]  = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000, 16'd0, 1'b0, 8'd0};
    tbl[4]  = '{4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000, 16'd0, 1'b0, 8'd0};
    tbl[5]  = '{4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000, 16'd0, 1'b1, 8'd3};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0001, 4'b0001, 4'b0000, 16'd0, 1'b1, 8'd3};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0001, 4'b0001, 4'b0000, 16'd0, 1'b1, 8'd2};
    tbl[8]  = '{4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000, 16'd0, 1'b1, 8'd1};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 16'd0, 1'b1, 8'd1};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 16'd0, 1'b0, 8'd0};
    tbl[11] = '{4'b0001, 1'b1, 4'b0000, 4'b0001, 4'b0000, 16'd0, 1'b0, 8'd0};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0001, 16'd1, 1'b1, 8'd2};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 16'd1, 1'b0, 8'd0};
    tbl[14] = '{4'b0001, 1'b1, 4'b0000, 4'b0001, 4'b0000, 16'd1, 1'b0, 8'd0};
    tbl[15] = '{4'b0001, 1'b1, 4'b0000, 4'b0001, 4'b0000, 16'd1, 1'b1, 8'd2};
    tbl[16] = '{4'b0000, 1'b1, 4'b0001, 4'b0000, 4'b0000, 16'd1, 1'b1, 8'd1};
    tbl[17] = '{4'b0000, 1'b1, 4'b0001, 4'b0001, 4'b0000, 16'd1, 1'b0, 8'd0};
    tbl[18] = '{4'b0000, 1'b1, 4'b0001, 4'b0001, 4'b0000, 16'd1, 1'b1, 8'd3};
    tbl[19] = '{4'b0000, 1'b1, 4'b0001, 4'b0001, 4'b0000, 16'd1, 1'b1, 8'd2};
    tbl[20] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 16'd1, 1'b1, 8'd1};
    a_if.tick_i = 1'b1;
    b_if.tick_i = 1'b1;
    a_if.in_i = '0;
    b_if.in_i = '0;
    for (int c = 0; c < 4; c++) begin
      set_dly(1'b0, c, 8'd2, 8'd3);
      set_dly(1'b1, c, 8'd80, 8'd20);
    end
    step();
    chk("rst_out_a", a_if.out_o, 0);
    chk("rst_pend_a", a_if.pending_o, 0);
    chk("rst_unst_a", a_if.unstable_o, 0);
    chk("rst_vac_a", a_if.vac_cnt_o, 0);
    chk("rst_nv_a", a_if.next_valid_o, 0);
    chk("rst_nd_a", a_if.next_dly_o, 0);
    chk("rst_out_b", b_if.out_o, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 21; i++) begin
      a_if.in_i = tbl[i].in;
      a_if.tick_i = tbl[i].tick;
      step();
      chk($sformatf("v%0d_out", i), a_if.out_o, tbl[i].out);
      chk($sformatf("v%0d_pend", i), a_if.pending_o, tbl[i].pend);
      chk($sformatf("v%0d_unst", i), a_if.unstable_o, tbl[i].unst);
      chk($sformatf("v%0d_vac", i), a_if.vac_cnt_o, tbl[i].vac);
      chk($sformatf("v%0d_nv", i), a_if.next_valid_o, tbl[i].nv);
      chk($sformatf("v%0d_nd", i), a_if.next_dly_o, tbl[i].nd);
    end
    // Long rise: out follows 81 clocks after the input edge
    a_if.tick_i = 1'b1;
    set_dly(1'b0, 0, 8'd80, 8'd20);
    a_if.in_i = 4'b0001;
    rise_at = 0;
    bad = 0;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (a_if.out_o[0]) begin
        rise_at = n;
        break;
      end
      if (!a_if.pending_o[0]) bad++;
    end
    chk("s1_rise_latency", rise_at, 81);
    chk("s1_pending_gaps", bad, 0);
    a_if.in_i = 4'b0000;
    repeat (30) step();
    chk("s1_fall_back", a_if.out_o[0], 0);
    // Reversal after 10 ticks on both instances
    a_u = 0; b_u = 0; a_hi = 0; b_rise = 0; b_fall = 0;
    a_if.in_i = 4'b0001;
    b_if.in_i = 4'b0001;
    for (int n = 1; n <= 130; n++) begin
      step();
      if (a_if.unstable_o[0]) a_u++;
      if (b_if.unstable_o[0]) b_u++;
      if (a_if.out_o[0]) a_hi++;
      if (b_if.out_o[0] && b_rise == 0) b_rise = n;
      if (!b_if.out_o[0] && b_rise != 0 && b_fall == 0) b_fall = n;
      if (n == 11) begin
        a_if.in_i = 4'b0000;
        b_if.in_i = 4'b0000;
      end
    end
    chk("s2_unst_pulses_a", a_u, 1);
    chk("s2_out_high_a", a_hi, 0);
    chk("s2_vac_a", a_if.vac_cnt_o, 2);
    chk("s2_pend_a", a_if.pending_o[0], 0);
    chk("s3_unst_pulses_b", b_u, 1);
    chk("s3_rise_b", b_rise, 81);
    chk("s3_fall_b", b_fall, 102);
    chk("s3_vac_b", b_if.vac_cnt_o, 0);
    chk("s3_pend_b", b_if.pending_o[0], 0);
    // Two channels scheduled together: minimum tracks the shorter one
    set_dly(1'b0, 0, 8'd60, 8'd3);
    set_dly(1'b0, 1, 8'd20, 8'd3);
    a_if.in_i = 4'b0011;
    for (int n = 1; n <= 70; n++) begin
      step();
      if (n == 2) chk("s4_nd_n2", a_if.next_dly_o, 20);
      if (n == 11) chk("s4_nd_n11", a_if.next_dly_o, 11);
      if (n == 20) chk("s4_ch1_before", a_if.out_o[1], 0);
      if (n == 21) begin
        chk("s4_nd_n21", a_if.next_dly_o, 1);
        chk("s4_ch1_fire", a_if.out_o[1], 1);
      end
      if (n == 22) begin
        chk("s4_nd_n22", a_if.next_dly_o, 40);
        chk("s4_nv_n22", a_if.next_valid_o, 1);
      end
      if (n == 60) chk("s4_ch0_before", a_if.out_o[0], 0);
      if (n == 61) chk("s4_ch0_fire", a_if.out_o[0], 1);
    end
    chk("s4_nv_idle", a_if.next_valid_o, 0);
    // Zero delay still takes one tick
    set_dly(1'b0, 2, 8'd0, 8'd3);
    a_if.in_i = 4'b0111;
    step();
    chk("s5_zero_sched", a_if.out_o[2], 0);
    chk("s5_zero_pend", a_if.pending_o[2], 1);
    step();
    chk("s5_zero_fire", a_if.out_o[2], 1);
    // Tick gated low for 5 clocks stretches the event by 5
    set_dly(1'b0, 3, 8'd10, 8'd3);
    a_if.in_i = 4'b1111;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == 3) a_if.tick_i = 1'b0;
      if (n == 8) a_if.tick_i = 1'b1;
      if (n == 15) chk("s5_gate_before", a_if.out_o[3], 0);
      if (n == 16) chk("s5_gate_fire", a_if.out_o[3], 1);
    end
    // Async reset with three falls pending
    for (int c = 0; c < 3; c++) set_dly(1'b0, c, 8'd3, 8'd50);
    a_if.in_i = 4'b1000;
    repeat (5) step();
    chk("s6_pend_before", a_if.pending_o, 4'b0111);
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_out", a_if.out_o, 0);
    chk("s6_rst_pend", a_if.pending_o, 0);
    chk("s6_rst_vac", a_if.vac_cnt_o, 0);
    chk("s6_rst_nv", a_if.next_valid_o, 0);
    chk("s6_rst_nd", a_if.next_dly_o, 0);
    a_if.in_i = 4'b0000;
    b_if.in_i = 4'b0000;
    step();
    step();
    rst = 1'b0;
    bad = 0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (a_if.out_o != 4'b0000 || a_if.pending_o != 4'b0000) bad++;
    end
    chk("s6_no_fire_after", bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
